dm_sized: RTL

Parametrised, handshaked data memory for the multicycle CPU. It replaces the fixed 1 KiB word-only data memory with a configurable-depth, byte-addressed, little-endian array. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Every access goes through a req/ack handshake with a programmable number of wait states, and misaligned or illegal accesses are reported instead of executed. It sits between the CPU datapath (ALU address, rt store data) and the MEM/WB stage controller.

---
 rtl/dm_sized_if.sv | 26 ++
 rtl/dm_sized.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dm_sized_if.sv
// dm_sized_if: request/response bundle between the CPU datapath
// and the sized data memory.
interface dm_sized_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic              ack;
    logic              busy;
    logic              misalign;

    modport master (
        output req, we, size, sign, addr, din,
        input  dout, ack, busy, misalign
    );

    modport slave (
        input  req, we, size, sign, addr, din,
        output dout, ack, busy, misalign
    );
endinterface

// File: rtl/dm_sized.sv
// dm_sized: byte-addressed little-endian data memory with
// byte/half/word access, load extension and wait states.
module dm_sized #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    dm_sized_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACC,
        S_ERR
    } state_t;

    state_t            st;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] a_q;
    logic              we_q;
    logic              sg_q;
    logic [1:0]        sz_q;
    logic [31:0]       d_q;

    logic [7:0]        mem [DEPTH];

    // Accepted accesses are aligned, so OR-ing in the low bits
    // yields the neighbouring byte lanes without an adder.
    logic [ADDR_W-1:0] a1, a2, a3;
    assign a1 = a_q | ADDR_W'(1);
    assign a2 = a_q | ADDR_W'(2);
    assign a3 = a_q | ADDR_W'(3);

    logic [7:0] b0, b1, b2, b3;
    assign b0 = mem[a_q];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    logic bad;
    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            (bus.size == 2'b11): bad = 1'b1;
            (bus.size == 2'b01): bad = bus.addr[0];
            (bus.size == 2'b10): bad = |bus.addr[1:0];
            default:             bad = 1'b0;
        endcase
    end

    logic [31:0] ld_val;
    always_comb begin
        ld_val = {b3, b2, b1, b0};
        unique case (1'b1)
            (sz_q == 2'b00): ld_val = {{24{sg_q & b0[7]}}, b0};
            (sz_q == 2'b01): ld_val = {{16{sg_q & b1[7]}}, b1, b0};
            default:         ld_val = {b3, b2, b1, b0};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= S_IDLE;
            cnt          <= 4'd0;
            a_q          <= '0;
            we_q         <= 1'b0;
            sg_q         <= 1'b0;
            sz_q         <= 2'b00;
            d_q          <= 32'd0;
            bus.dout     <= 32'd0;
            bus.ack      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.misalign <= 1'b0;
        end else begin
            bus.ack      <= 1'b0;
            bus.misalign <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (bus.req) begin
                        a_q      <= bus.addr;
                        we_q     <= bus.we;
                        sz_q     <= bus.size;
                        sg_q     <= bus.sign;
                        d_q      <= bus.din;
                        cnt      <= 4'(WAIT_CYCLES);
                        bus.busy <= 1'b1;
                        if (bad)
                            st <= S_ERR;
                        else if (WAIT_CYCLES == 0)
                            st <= S_ACC;
                        else
                            st <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1)
                        st <= S_ACC;
                end
                S_ACC: begin
                    if (!we_q)
                        bus.dout <= ld_val;
                    bus.ack  <= 1'b1;
                    bus.busy <= 1'b0;
                    st       <= S_IDLE;
                end
                S_ERR: begin
                    bus.ack      <= 1'b1;
                    bus.misalign <= 1'b1;
                    bus.busy     <= 1'b0;
                    st           <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    // Array is not reset; an aborted access never reaches ACC.
    always_ff @(posedge clk) begin
        if (st == S_ACC && we_q) begin
            mem[a_q] <= d_q[7:0];
            if (sz_q != 2'b00)
                mem[a1] <= d_q[15:8];
            if (sz_q == 2'b10) begin
                mem[a2] <= d_q[23:16];
                mem[a3] <= d_q[31:24];
            end
        end
    end
endmodule
